// File: rtl/btn_pkg.sv
// Shared types and board defaults for push-button conditioning.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package btn_pkg;

  // Debounce FSM states
  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    PRESSED         = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } btn_state_t;

  // Defaults for the 12 MHz board clock
  localparam int DEF_SYNC_STAGES       = 2;
  localparam int DEF_DEBOUNCE_CYCLES   = 120000;    // 10 ms
  localparam int DEF_LONG_PRESS_CYCLES = 12000000;  // 1 s

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser bringing one asynchronous input into the clock domain.
// Latency: STAGES clock edges from input to o_q.
// Backpressure: none; samples every cycle. STAGES must be at least 2.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift chain; reset clears every stage so no stale level leaks out after reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Debounces a raw push-button into a clean level plus press/release/long-press pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges from a stable input change to btn_level.
// Backpressure: none; pulses are single-cycle and must be consumed when they occur.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic i_sysclk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_btn_level,
  output logic o_btn_press,
  output logic o_btn_release,
  output logic o_btn_long,
  output logic o_btn_held
);

  localparam int SW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [SW-1:0] STAB_LAST = SW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_ONE  = SW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic            w_btn_s;
  btn_state_t      r_state, w_state_nxt;
  logic [SW-1:0]   r_stab, w_stab_nxt;
  logic [HW-1:0]   r_hold, w_hold_nxt;
  logic            r_level, w_level_nxt;
  logic            r_press, w_press_nxt;
  logic            r_release, w_release_nxt;
  logic            r_long, w_long_nxt;
  logic            r_held, w_held_nxt;

  // Only the synchronised copy of the pin feeds the logic below
  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (i_sysclk),
    .i_rst (i_reset),
    .i_d   (i_btn),
    .o_q   (w_btn_s)
  );

  // Next-state, counter and output decode; pulses default low every cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_stab_nxt    = r_stab;
    w_hold_nxt    = r_hold;
    w_level_nxt   = r_level;
    w_held_nxt    = r_held;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;

    case (r_state)
      RELEASED: begin
        if (w_btn_s) begin
          w_stab_nxt  = '0;
          w_state_nxt = CONFIRM_PRESS;
        end
      end

      CONFIRM_PRESS: begin
        if (!w_btn_s) begin
          w_state_nxt = RELEASED;
        end else if (r_stab == STAB_LAST) begin
          w_state_nxt = PRESSED;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
          w_hold_nxt  = '0;
        end else begin
          w_stab_nxt = r_stab + STAB_ONE;
        end
      end

      PRESSED: begin
        // Hold time only advances while here; saturation keeps the long pulse one-shot
        if (r_hold != HOLD_MAX) begin
          w_hold_nxt = r_hold + HOLD_ONE;
        end
        // Fires even if the button drops this same cycle
        if (r_hold == HOLD_LAST) begin
          w_long_nxt = 1'b1;
          w_held_nxt = 1'b1;
        end
        if (!w_btn_s) begin
          w_stab_nxt  = '0;
          w_state_nxt = CONFIRM_RELEASE;
        end
      end

      CONFIRM_RELEASE: begin
        if (w_btn_s) begin
          w_state_nxt = PRESSED;
        end else if (r_stab == STAB_LAST) begin
          w_state_nxt   = RELEASED;
          w_level_nxt   = 1'b0;
          w_held_nxt    = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_stab_nxt = r_stab + STAB_ONE;
        end
      end

      default: begin
        w_state_nxt = RELEASED;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge i_sysclk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= RELEASED;
      r_stab    <= '0;
      r_hold    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_stab    <= w_stab_nxt;
      r_hold    <= w_hold_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_long    <= w_long_nxt;
      r_held    <= w_held_nxt;
    end
  end

  assign o_btn_level   = r_level;
  assign o_btn_press   = r_press;
  assign o_btn_release = r_release;
  assign o_btn_long    = r_long;
  assign o_btn_held    = r_held;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with small cycle counts.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_btn_debounce;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LONG = 16;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic level, press, rel, lng, held;

  btn_debounce #(
    .SYNC_STAGES       (SYNC),
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONG)
  ) dut (
    .i_sysclk      (clk),
    .i_reset       (rst),
    .i_btn         (btn),
    .o_btn_level   (level),
    .o_btn_press   (press),
    .o_btn_release (rel),
    .o_btn_long    (lng),
    .o_btn_held    (held)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: debounced level flips when the last DEB+1 synchronised
  // samples all disagree with it; long press fires after LONG cycles during
  // which the level was high and the synchronised button agreed.
  bit raw_hist[$];
  bit s_hist[$];
  bit m_level, m_press, m_rel, m_long, m_held, m_s_prev;
  int m_hold;

  // Per-sequence observation counters
  int edge_no;
  int cnt_press, cnt_rel, cnt_long;
  int press_edge, rel_edge, long_edge;
  bit held_seen;

  typedef struct {
    bit btn;
    int cycles;
    int n_press;
    int n_rel;
    int n_long;
    bit level;
    bit held;
  } seg_t;

  seg_t segs[13];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_hist.delete();
    s_hist.delete();
    m_level = 0; m_press = 0; m_rel = 0; m_long = 0; m_held = 0;
    m_s_prev = 0; m_hold = 0;
  endtask

  task automatic model_edge(input bit b);
    bit s;
    bit flip;
    s = (raw_hist.size() >= SYNC) ? raw_hist[raw_hist.size() - SYNC] : 1'b0;
    raw_hist.push_back(b);
    if (raw_hist.size() > 8) void'(raw_hist.pop_front());
    s_hist.push_back(s);
    if (s_hist.size() > DEB + 1) void'(s_hist.pop_front());
    m_press = 0; m_rel = 0; m_long = 0;
    if (m_level && m_s_prev) begin
      m_hold++;
      if (m_hold == LONG) begin
        m_long = 1;
        m_held = 1;
      end
    end
    if (s_hist.size() == DEB + 1) begin
      flip = 1;
      foreach (s_hist[i]) if (s_hist[i] == m_level) flip = 0;
      if (flip) begin
        m_level = !m_level;
        if (m_level) begin
          m_press = 1;
          m_hold  = 0;
        end else begin
          m_rel  = 1;
          m_held = 0;
        end
      end
    end
    m_s_prev = s;
  endtask

  task automatic clear_obs();
    edge_no = 0;
    cnt_press = 0; cnt_rel = 0; cnt_long = 0;
    press_edge = -1; rel_edge = -1; long_edge = -1;
    held_seen = 0;
  endtask

  // One clock edge with btn driven to b; compares DUT against the model
  task automatic tick(input bit b);
    btn = b;
    @(posedge clk);
    #1;
    edge_no++;
    model_edge(b);
    check("cycle {level,press,release,long,held}",
          int'({level, press, rel, lng, held}),
          int'({m_level, m_press, m_rel, m_long, m_held}));
    if (press === 1'b1) begin cnt_press++; press_edge = edge_no; end
    if (rel   === 1'b1) begin cnt_rel++;   rel_edge   = edge_no; end
    if (lng   === 1'b1) begin cnt_long++;  long_edge  = edge_no; end
    if (held  === 1'b1) held_seen = 1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock
  task automatic mid_reset(input bit b);
    btn = b;
    rst = 1'b1;
    #1;
    check("reset outputs", int'({level, press, rel, lng, held}), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
  endtask

  initial begin
    bit val;
    int len;

    segs[0]  = '{0, 10, 0, 0, 0, 0, 0};
    segs[1]  = '{1,  2, 0, 0, 0, 0, 0};
    segs[2]  = '{0,  2, 0, 0, 0, 0, 0};
    segs[3]  = '{1,  2, 0, 0, 0, 0, 0};
    segs[4]  = '{0, 10, 0, 0, 0, 0, 0};
    segs[5]  = '{1, 30, 1, 0, 1, 1, 1};
    segs[6]  = '{0, 10, 0, 1, 0, 0, 0};
    segs[7]  = '{1, 10, 1, 0, 0, 1, 0};
    segs[8]  = '{0, 10, 0, 1, 0, 0, 0};
    segs[9]  = '{1,  3, 0, 0, 0, 0, 0};
    segs[10] = '{0,  1, 0, 0, 0, 0, 0};
    segs[11] = '{1, 10, 1, 0, 0, 1, 0};
    segs[12] = '{0, 10, 0, 1, 0, 0, 0};

    rst = 1'b0;
    btn = 1'b0;
    @(negedge clk);
    mid_reset(1'b0);

    // Segment table: pulse counts within each segment and the level/held left behind
    for (int i = 0; i < 13; i++) begin
      clear_obs();
      repeat (segs[i].cycles) tick(segs[i].btn);
      check($sformatf("seg%0d press count", i), cnt_press, segs[i].n_press);
      check($sformatf("seg%0d release count", i), cnt_rel, segs[i].n_rel);
      check($sformatf("seg%0d long count", i), cnt_long, segs[i].n_long);
      check($sformatf("seg%0d level", i), int'(level), int'(segs[i].level));
      check($sformatf("seg%0d held", i), int'(held), int'(segs[i].held));
    end

    // Clean press: press on edge 7, long 16 later, release 7 edges after the fall
    mid_reset(1'b0);
    repeat (30) tick(1'b1);
    check("clean press edge", press_edge, 7);
    check("clean long edge", long_edge, 23);
    check("clean held", int'(held), 1);
    clear_obs();
    repeat (10) tick(1'b0);
    check("clean release edge", rel_edge, 7);
    check("clean held after release", int'(held), 0);

    // Short press: no long event, held never set
    mid_reset(1'b0);
    repeat (10) tick(1'b1);
    repeat (12) tick(1'b0);
    check("short press edge", press_edge, 7);
    check("short release edge", rel_edge, 17);
    check("short long count", cnt_long, 0);
    check("short held seen", int'(held_seen), 0);

    // Release glitch: two low cycles freeze the hold count but keep the level
    mid_reset(1'b0);
    repeat (10) tick(1'b1);
    repeat (2) tick(1'b0);
    repeat (20) tick(1'b1);
    check("glitch release count", cnt_rel, 0);
    check("glitch long edge", long_edge, 25);
    check("glitch long count", cnt_long, 1);
    check("glitch level", int'(level), 1);

    // Reset while held, button still down: fresh press 7 edges after deassert
    mid_reset(1'b0);
    repeat (26) tick(1'b1);
    check("pre-reset held", int'(held), 1);
    mid_reset(1'b1);
    repeat (10) tick(1'b1);
    check("post-reset press edge", press_edge, 7);
    check("post-reset release count", cnt_rel, 0);

    // Randomised runs, including long holds that exercise hold-counter saturation
    mid_reset(1'b0);
    val = 1'b0;
    for (int r = 0; r < 300; r++) begin
      val = ~val;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70))
                                        : int'($urandom_range(1, 7));
      repeat (len) tick(val);
      if (r % 100 == 99) mid_reset(val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
